// File: rtl/decoder_addr_seq_if.sv
// Handshake/bus bundle between the address sequencer (master) and its consumer (slave).
// Carries the run programming inputs, the address beat handshake and the status flags.
interface decoder_addr_seq_if #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = ADDR_W + 1
);
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] stride;
    logic [CNT_W-1:0]  count;
    logic              a_ready;
    logic [ADDR_W-1:0] A;
    logic              a_valid;
    logic              busy;
    logic              done;

    modport master (
        input  start, base, stride, count, a_ready,
        output A, a_valid, busy, done
    );

    modport slave (
        output start, base, stride, count, a_ready,
        input  A, a_valid, busy, done
    );
endinterface

// File: rtl/decoder_addr_seq.sv
// Registered address sequencer feeding a 4-to-16 decoder: emits base + i*stride for count beats, then pulses done.
// Optional macro DECODER_ADDR_SEQ_ABORT_EN adds an abort input that cancels a run without a done pulse.
module decoder_addr_seq #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic clk,
    input  logic rst_n,
`ifdef DECODER_ADDR_SEQ_ABORT_EN
    input  logic abort,
`endif
    decoder_addr_seq_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_next;
    logic [ADDR_W-1:0] r_stride;
    logic [ADDR_W-1:0] w_stride_next;
    logic [CNT_W-1:0]  r_remaining;
    logic [CNT_W-1:0]  w_remaining_next;
    logic              r_a_valid;
    logic              r_busy;
    logic              r_done;
    logic              w_abort;

`ifdef DECODER_ADDR_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_state_next     = r_state;
        w_addr_next      = r_addr;
        w_stride_next    = r_stride;
        w_remaining_next = r_remaining;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.count != '0) begin
                        w_addr_next      = bus.base;
                        w_stride_next    = bus.stride;
                        w_remaining_next = bus.count;
                        w_state_next     = S_RUN;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_RUN: begin
                // Abort wins over an accept on the same edge; the address is left as-is.
                if (w_abort) begin
                    w_state_next = S_IDLE;
                end else if (bus.a_ready) begin
                    if (r_remaining > CNT_W'(1)) begin
                        w_addr_next      = r_addr + r_stride;
                        w_remaining_next = r_remaining - CNT_W'(1);
                    end else begin
                        w_remaining_next = '0;
                        w_state_next     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so every output comes straight off a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_stride    <= '0;
            r_remaining <= '0;
            r_a_valid   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_addr      <= w_addr_next;
            r_stride    <= w_stride_next;
            r_remaining <= w_remaining_next;
            r_a_valid   <= (w_state_next == S_RUN);
            r_busy      <= (w_state_next != S_IDLE);
            r_done      <= (w_state_next == S_DONE);
        end
    end

    assign bus.A       = r_addr;
    assign bus.a_valid = r_a_valid;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_decoder_addr_seq.sv
// Self-checking bench for decoder_addr_seq: table of programmed runs checked through an address scoreboard,
// plus hand-written reset, mid-run reset and (when enabled) abort sequences.
module tb_decoder_addr_seq;
    localparam int AW = 4;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic rst_n;
`ifdef DECODER_ADDR_SEQ_ABORT_EN
    logic abort;
`endif

    always #5 clk = ~clk;

    decoder_addr_seq_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

    decoder_addr_seq #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef DECODER_ADDR_SEQ_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] stride;
        logic [CW-1:0] count;
        int            ready_mode;   // 0 always ready, 1 alternating, 2 random
        bit            mid_start;    // pulse start during the run
        logic [AW-1:0] exp_last;     // hand-computed final address
    } vec_t;

    vec_t          vecs[6];
    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [AW-1:0] exp_q[$];
    int            beats;
    bit            any_valid;
    logic [AW-1:0] last_a;
    string         cur_tag;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d, required %0d", cur_tag, name, act, exp);
        end
    endtask

    // One clock: score any beat accepted on this edge, then sample 1 ns after the edge.
    task automatic tick();
        logic          hold;
        logic [AW-1:0] hv;
        logic [AW-1:0] e;
        logic          acc;
        hold = bus.a_valid && !bus.a_ready && rst_n;
        hv   = bus.A;
        acc  = bus.a_valid && bus.a_ready && rst_n;
`ifdef DECODER_ADDR_SEQ_ABORT_EN
        acc  = acc && !abort;
`endif
        if (acc) begin
            beats++;
            last_a = bus.A;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s/extra_beat: got A=%0d, required no beat", cur_tag, bus.A);
            end else begin
                e = exp_q.pop_front();
                chk("beat_addr", int'(bus.A), int'(e));
                $display("[%s] beat %0d A=%0d expected %0d", cur_tag, beats, bus.A, e);
            end
        end
        @(posedge clk);
        #1;
        if (bus.a_valid === 1'b1) any_valid = 1'b1;
        if (hold) chk("hold_A", int'(bus.A), int'(hv));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        cur_tag = tag;
        exp_q.delete();
        beats     = 0;
        any_valid = 1'b0;
        for (int i = 0; i < int'(v.count); i++)
            exp_q.push_back(AW'(int'(v.base) + i * int'(v.stride)));
        bus.start   = 1'b1;
        bus.base    = v.base;
        bus.stride  = v.stride;
        bus.count   = v.count;
        bus.a_ready = 1'b1;
        tick();
        bus.start  = 1'b0;
        // Scramble the programming inputs; a correct run must not re-read them.
        bus.base   = ~v.base;
        bus.stride = v.stride + AW'(1);
        bus.count  = v.count ^ CW'(3);
        if (v.count != 0) begin
            chk("start_valid", int'(bus.a_valid), 1);
            chk("start_A", int'(bus.A), int'(v.base));
        end
        chk("start_busy", int'(bus.busy), 1);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 300) begin
            case (v.ready_mode)
                0:       bus.a_ready = 1'b1;
                1:       bus.a_ready = (cyc % 2 == 1);
                default: bus.a_ready = 1'($urandom_range(0, 1));
            endcase
            bus.start = (v.mid_start && cyc == 2);
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        if (bus.done !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s/timeout: got no done after %0d cycles, required done", tag, cyc);
        end else begin
            chk("done_valid", int'(bus.a_valid), 0);
            chk("done_busy", int'(bus.busy), 1);
            if (v.ready_mode == 0) chk("done_latency", cyc, int'(v.count));
            tick();
            chk("done_len", int'(bus.done), 0);
            chk("idle_busy", int'(bus.busy), 0);
            chk("idle_valid", int'(bus.a_valid), 0);
        end
        chk("beat_count", beats, int'(v.count));
        chk("queue_empty", exp_q.size(), 0);
        if (v.count != 0) chk("last_A", int'(last_a), int'(v.exp_last));
        else              chk("never_valid", int'(any_valid), 0);
        $display("[%s] run base=%0d stride=%0d count=%0d beats=%0d", tag, v.base, v.stride, v.count, beats);
    endtask

    initial begin
        vecs[0] = '{base: 4'd0,  stride: 4'd1,  count: 5'd16, ready_mode: 0, mid_start: 1'b0, exp_last: 4'd15};
        vecs[1] = '{base: 4'd14, stride: 4'd3,  count: 5'd4,  ready_mode: 1, mid_start: 1'b0, exp_last: 4'd7};
        vecs[2] = '{base: 4'd5,  stride: 4'd0,  count: 5'd3,  ready_mode: 0, mid_start: 1'b0, exp_last: 4'd5};
        vecs[3] = '{base: 4'd9,  stride: 4'd7,  count: 5'd20, ready_mode: 2, mid_start: 1'b1, exp_last: 4'd14};
        vecs[4] = '{base: 4'd3,  stride: 4'd15, count: 5'd31, ready_mode: 0, mid_start: 1'b1, exp_last: 4'd5};
        vecs[5] = '{base: 4'd0,  stride: 4'd0,  count: 5'd0,  ready_mode: 0, mid_start: 1'b0, exp_last: 4'd0};

`ifdef DECODER_ADDR_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        // Reset held for two edges with start asserted.
        cur_tag     = "reset";
        rst_n       = 1'b0;
        bus.start   = 1'b1;
        bus.base    = 4'd5;
        bus.stride  = 4'd1;
        bus.count   = 5'd3;
        bus.a_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_A", int'(bus.A), 0);
            chk("rst_valid", int'(bus.a_valid), 0);
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_done", int'(bus.done), 0);
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        tick();
        chk("post_rst_busy", int'(bus.busy), 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Mid-run reset after the third beat of a ten-beat run.
        cur_tag = "midrst";
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(AW'(2 + i));
        beats       = 0;
        bus.start   = 1'b1;
        bus.base    = 4'd2;
        bus.stride  = 4'd1;
        bus.count   = 5'd10;
        bus.a_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 20 && beats < 3; c++) tick();
        chk("midrst_beats", beats, 3);
        rst_n = 1'b0;
        tick();
        chk("midrst_A", int'(bus.A), 0);
        chk("midrst_valid", int'(bus.a_valid), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_done", int'(bus.done), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("midrst_no_done", int'(bus.done), 0);
        end
        run_vec(vecs[2], "after_rst");

`ifdef DECODER_ADDR_SEQ_ABORT_EN
        // Abort together with an accept on beat 5 of an eight-beat run.
        cur_tag = "abort";
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(AW'(1 + 2 * i));
        beats       = 0;
        bus.start   = 1'b1;
        bus.base    = 4'd1;
        bus.stride  = 4'd2;
        bus.count   = 5'd8;
        bus.a_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 20 && beats < 4; c++) tick();
        chk("abort_beats", beats, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", int'(bus.a_valid), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_A", int'(bus.A), 9);
        chk("abort_done", int'(bus.done), 0);
        tick();
        chk("abort_no_done", int'(bus.done), 0);
        exp_q.delete();
        run_vec(vecs[1], "after_abort");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/decoder_addr_seq.md
# decoder_addr_seq

Registered address sequencer that sits directly upstream of the 4-to-16 `decoder` and drives its `A` input. It emits a programmed run of addresses (base, stride, count) one per accepted beat under a valid/ready handshake, then pulses `done`. The decoder stays purely combinational; this block owns all address timing, so `Z` changes only on `clk` edges.

## Interface
- `ADDR_W`, default 4: address width; must match the decoder input width.
- `CNT_W`, default `ADDR_W+1`: width of the beat count.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset; sampled on the rising `clk` edge.
- `start`  in  1  launch request; honoured only in IDLE.
- `base`  in  ADDR_W  first address, sampled with `start`.
- `stride`  in  ADDR_W  address increment per beat, sampled with `start`.
- `count`  in  CNT_W  number of beats, sampled with `start`.
- `a_ready`  in  1  downstream accepts the current address.
- `A`  out  ADDR_W  registered address to the decoder.
- `a_valid`  out  1  `A` holds a beat.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `a_valid`=0, `busy`=0, `A` holds its last value. On `start`=1:
  - `count`≠0: latch `stride`, `A`<=`base`, `remaining`<=`count`; go to RUN.
  - `count`=0: go to DONE; no beat is issued.
- RUN: `a_valid`=1, `busy`=1. A beat is accepted on a cycle with `a_valid`&&`a_ready`.
  - Accepted and `remaining`>1: `A`<=`A`+`stride`, `remaining`<=`remaining`-1.
  - Accepted and `remaining`=1: go to DONE; `A` holds the last address.
  - No accept: `A` and `remaining` hold.
- DONE: `a_valid`=0, `busy`=1, `done`=1 for exactly one cycle; then go to IDLE.
- `start` is ignored in RUN and DONE. Inputs sampled with `start` are not re-read during a run.
- Address arithmetic is modulo 2^ADDR_W and wraps silently; for example, `base`=14, `stride`=3 gives 14, 1, 4, ...
- `stride`=0 repeats `base` for all `count` beats.
- `count` up to 2^CNT_W-1 is legal; addresses wrap as needed.

## Timing
- Reset values: `A`=0, `a_valid`=0, `busy`=0, `done`=0, state IDLE, `remaining`=0.
- `rst_n` low on any edge overrides all other inputs, including mid-run; no `done` pulse is issued for the interrupted run.
- Start latency: `start` sampled at edge k; `a_valid`=1 and `A`=`base` from edge k+1.
- Throughput: one beat per cycle while `a_ready`=1.
- Completion: last beat accepted at edge m; `done`=1 during cycle m+1 to m+2, with `a_valid`=0. IDLE from edge m+2, so the earliest next `start` is sampled at edge m+2.
- `count`=0: `start` at edge k gives `done`=1 in cycle k+1 to k+2; `a_valid` never rises.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `a_ready` may toggle freely. `A` is stable while `a_valid`=1 and `a_ready`=0.

## Configuration
- Macro: `DECODER_ADDR_SEQ_ABORT_EN`.
- Defined: adds input port `abort` (1 bit).
  - `abort`=1 in RUN forces IDLE at the next edge: `a_valid`=0, `busy`=0, no `done` pulse, `A` holds.
  - `abort` takes priority over a same-cycle accept.
  - `abort` is ignored in IDLE and DONE.
- Undefined: the `abort` port does not exist; every run completes with `done`.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges with `start`=1 -> `A`=0, `a_valid`=0, `busy`=0, `done`=0 throughout.
- Basic sweep: `base`=0, `stride`=1, `count`=16, `a_ready`=1 -> `A`=0..15 on 16 consecutive cycles. Decoder `Z` walks one-hot from bit 0 to bit 15. `done` pulses the cycle after `A`=15.
- Wrap and backpressure: `base`=14, `stride`=3, `count`=4, `a_ready` low on every other cycle -> `A` sequence 14, 1, 4, 7. Each value is held while `a_ready`=0. `done` pulses once.
- Zero count, and start during a run: `count`=0 -> `done` pulse one cycle after `start`, `a_valid` never rises. `start` asserted mid-run -> ignored; the run length is unchanged.
- Mid-run reset: drop `rst_n` after the 3rd beat of a 10-beat run -> next cycle all outputs at reset values, no `done`. A fresh `start` then runs normally.
- Abort (with `DECODER_ADDR_SEQ_ABORT_EN` defined): `abort`=1 together with `a_ready`=1 on beat 5 -> `a_valid`=0 next cycle, `A` holds beat 5's address, `done` stays 0.
